// File: rtl/sram_fifo_prefetch.sv
// SRAM-backed FIFO with a 2-entry prefetch output stage (first-word-fall-through).
// Ports: clk/rst, flush_i, s_* write handshake, m_* read handshake, count_o, almost_full_o/almost_empty_o.
module sram_fifo_prefetch #(
  parameter int DEPTH_LG2  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [DEPTH_LG2+1:0]  count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam int AW  = DEPTH_LG2;
  localparam int PW  = DEPTH_LG2 + 1;
  localparam int CW  = DEPTH_LG2 + 2;
  localparam int D   = 1 << DEPTH_LG2;
  localparam int CAP = D + 2;

  typedef logic [PW-1:0]         ptr_t;
  typedef logic [CW-1:0]         cnt_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  data_t mem [D];

  ptr_t  wr_q, wr_d, rd_q, rd_d, occ, occ_d;
  cnt_t  cnt_q, cnt_d;
  logic  rdy_q, rdy_d;
  logic  v0_q, v0_d, v1_q, v1_d;
  data_t h0_q, h0_d, h1_q, h1_d;
  logic  af_q, af_d, ae_q, ae_d;
  logic  push, pop, issue;
  data_t rdata;

  assign occ   = wr_q - rd_q;
  assign push  = s_valid_i & rdy_q;
  assign pop   = v0_q & m_ready_i;
  // Refill whenever the stage would hold < 2 words after this cycle's pop.
  assign issue = (occ != '0) & (~v1_q | pop);
  assign rdata = mem[rd_q[AW-1:0]];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ;
    rdy_d = rdy_q;
    cnt_d = cnt_q;
    v0_d  = v0_q;
    v1_d  = v1_q;
    h0_d  = h0_q;
    h1_d  = h1_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      rdy_d = 1'b1;
      cnt_d = '0;
      v0_d  = 1'b0;
      v1_d  = 1'b0;
    end else begin
      wr_d  = wr_q + PW'(push);
      rd_d  = rd_q + PW'(issue);
      occ_d = wr_d - rd_d;
      rdy_d = occ_d < PW'(D);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (pop) begin
        v0_d = v1_q;
        v1_d = 1'b0;
        if (v1_q) h0_d = h1_q;
      end
      // SRAM read data lands in the first free slot after the shift.
      if (issue) begin
        if (!v0_d) begin
          h0_d = rdata;
          v0_d = 1'b1;
        end else begin
          h1_d = rdata;
          v1_d = 1'b1;
        end
      end
    end
    af_d = cnt_d >= CW'(AF_THRESH);
    ae_d = cnt_d <= CW'(AE_THRESH);
  end

  always_ff @(posedge clk) begin
    if (push && !flush_i && !rst) mem[wr_q[AW-1:0]] <= s_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      rdy_q <= 1'b1;
      cnt_q <= '0;
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      h0_q  <= '0;
      h1_q  <= '0;
      af_q  <= 1'b0;
      ae_q  <= 1'b1;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      rdy_q <= rdy_d;
      cnt_q <= cnt_d;
      v0_q  <= v0_d;
      v1_q  <= v1_d;
      h0_q  <= h0_d;
      h1_q  <= h1_d;
      af_q  <= af_d;
      ae_q  <= ae_d;
    end
  end

  assign s_ready_o      = rdy_q;
  assign m_valid_o      = v0_q;
  assign m_data_o       = h0_q;
  assign count_o        = cnt_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;

`ifndef SYNTHESIS
  a_cap : assert property (@(posedge clk) disable iff (rst)
    cnt_q <= CW'(CAP));
  a_hold : assert property (@(posedge clk) disable iff (rst)
    (v0_q && !m_ready_i && !flush_i) |=> v0_q);
`endif

endmodule

// File: tb/tb_sram_fifo_prefetch.sv
// Scoreboard bench for sram_fifo_prefetch: directed reset, single-word,
// fill/drain, streaming, random backpressure and flush sequences.
module tb_sram_fifo_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        s_valid_i = 1'b1;
  logic        s_ready_o;
  logic [31:0] s_data_i = 32'hDEAD_BEEF;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic [31:0] m_data_o;
  logic [5:0]  count_o;
  logic        almost_full_o;
  logic        almost_empty_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int mcount   = 0;
  logic [31:0] q [$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  sram_fifo_prefetch #(
    .DEPTH_LG2(4), .DATA_WIDTH(32), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .count_o(count_o), .almost_full_o(almost_full_o),
    .almost_empty_o(almost_empty_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: inputs are stable from posedge+1, outputs are
  // registered, so the negedge view is the handshake of the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcount = 0;
      prev_hold = 1'b0;
    end else begin
      check("count", 32'(count_o), 32'(mcount));
      check("count_cap", 32'(count_o <= 6'd18), 32'd1);
      check("almost_full", 32'(almost_full_o), 32'(mcount >= 14));
      check("almost_empty", 32'(almost_empty_o), 32'(mcount <= 2));
      if (prev_hold) begin
        check("hold_valid", 32'(m_valid_o), 32'd1);
        check("hold_data", m_data_o, prev_data);
      end
      prev_hold = m_valid_o && !m_ready_i && !flush_i;
      prev_data = m_data_o;
      if (flush_i) begin
        q.delete();
        mcount = 0;
      end else begin
        if (m_valid_o && m_ready_i) begin
          if (q.size() == 0) begin
            check("pop_unexpected", m_data_o, 32'hFFFF_FFFF);
          end else begin
            check("pop_data", m_data_o, q.pop_front());
          end
          mcount--;
          n_pops++;
        end
        if (s_valid_i && s_ready_o) begin
          q.push_back(s_data_i);
          mcount++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int sent;
    int cyc;
    int base;

    // Reset held 3 cycles with a write request pending.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(s_ready_o), 32'd1);
      check("rst_valid", 32'(m_valid_o), 32'd0);
      check("rst_count", 32'(count_o), 32'd0);
      check("rst_ae", 32'(almost_empty_o), 32'd1);
      check("rst_af", 32'(almost_full_o), 32'd0);
      check("rst_data", m_data_o, 32'd0);
    end
    tick();
    rst = 1'b0;
    s_valid_i = 1'b0;
    @(negedge clk);
    check("post_rst_count", 32'(count_o), 32'd0);
    check("post_rst_valid", 32'(m_valid_o), 32'd0);

    // Single word: push in cycle 0, visible in cycle 2.
    tick();
    s_valid_i = 1'b1;
    s_data_i = 32'hA5;
    m_ready_i = 1'b1;
    @(negedge clk);
    check("sw_c0_count", 32'(count_o), 32'd0);
    tick();
    s_valid_i = 1'b0;
    @(negedge clk);
    check("sw_c1_count", 32'(count_o), 32'd1);
    check("sw_c1_valid", 32'(m_valid_o), 32'd0);
    tick();
    @(negedge clk);
    check("sw_c2_valid", 32'(m_valid_o), 32'd1);
    check("sw_c2_data", m_data_o, 32'hA5);
    check("sw_c2_count", 32'(count_o), 32'd1);
    tick();
    @(negedge clk);
    check("sw_c3_valid", 32'(m_valid_o), 32'd0);
    check("sw_c3_count", 32'(count_o), 32'd0);

    // Fill with no consumer: capacity is 16 + 2.
    tick();
    m_ready_i = 1'b0;
    s_valid_i = 1'b1;
    acc = 0;
    s_data_i = 0;
    repeat (30) begin
      @(negedge clk);
      if (s_ready_o) acc++;
      tick();
      s_data_i = acc;
    end
    s_valid_i = 1'b0;
    @(negedge clk);
    check("fill_accepted", acc, 32'd18);
    check("fill_count", 32'(count_o), 32'd18);
    check("fill_ready", 32'(s_ready_o), 32'd0);
    check("fill_af", 32'(almost_full_o), 32'd1);
    check("fill_head", m_data_o, 32'd0);
    tick();
    m_ready_i = 1'b1;
    repeat (24) tick();
    @(negedge clk);
    check("drain_count", 32'(count_o), 32'd0);
    check("drain_ae", 32'(almost_empty_o), 32'd1);
    check("drain_valid", 32'(m_valid_o), 32'd0);
    check("drain_all", q.size(), 32'd0);

    // Streaming: first pop in cycle 2, then one per cycle.
    tick();
    for (int c = 0; c < 104; c++) begin
      s_valid_i = (c < 100);
      s_data_i = 1000 + c;
      m_ready_i = 1'b1;
      @(negedge clk);
      if (c >= 2 && c < 102) check("st_valid", 32'(m_valid_o), 32'd1);
      else check("st_idle", 32'(m_valid_o), 32'd0);
      if (c >= 2 && c <= 100) check("st_count", 32'(count_o), 32'd2);
      if (c < 100) check("st_ready", 32'(s_ready_o), 32'd1);
      tick();
    end

    // Random backpressure on both sides.
    sent = 0;
    cyc = 0;
    base = n_pops;
    while ((sent < 500 || n_pops != base + 500) && cyc < 6000) begin
      s_valid_i = (sent < 500) && ($urandom_range(0, 1) == 1);
      s_data_i = 32'h5000_0000 + sent;
      m_ready_i = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (s_valid_i && s_ready_o) sent++;
      tick();
      cyc++;
    end
    s_valid_i = 1'b0;
    m_ready_i = 1'b0;
    check("rand_done", 32'(n_pops - base), 32'd500);

    // Flush with 10 words held and a read issued in the flush cycle.
    acc = 0;
    cyc = 0;
    s_valid_i = 1'b1;
    while (acc < 10 && cyc < 100) begin
      s_data_i = 32'h100 + acc;
      @(negedge clk);
      if (s_ready_o) acc++;
      tick();
      cyc++;
    end
    s_valid_i = 1'b0;
    @(negedge clk);
    check("fl_pre_count", 32'(count_o), 32'd10);
    check("fl_pre_valid", 32'(m_valid_o), 32'd1);
    tick();
    flush_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i = 32'h77;
    m_ready_i = 1'b1;
    @(negedge clk);
    tick();
    flush_i = 1'b0;
    s_data_i = 32'h33;
    m_ready_i = 1'b0;
    @(negedge clk);
    check("fl_count", 32'(count_o), 32'd0);
    check("fl_valid", 32'(m_valid_o), 32'd0);
    check("fl_ready", 32'(s_ready_o), 32'd1);
    tick();
    s_valid_i = 1'b0;
    @(negedge clk);
    check("fl_c1_valid", 32'(m_valid_o), 32'd0);
    tick();
    @(negedge clk);
    check("fl_c2_valid", 32'(m_valid_o), 32'd1);
    check("fl_c2_data", m_data_o, 32'h33);
    tick();
    m_ready_i = 1'b1;
    tick();
    @(negedge clk);
    check("fl_end_valid", 32'(m_valid_o), 32'd0);
    check("fl_end_count", 32'(count_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_fifo_prefetch.md
Name: sram_fifo_prefetch

Overview:
- Parameterised SRAM-backed FIFO with valid/ready handshakes on both sides.
- A 2-entry prefetch output stage hides the 1-cycle SRAM read latency, giving first-word-fall-through output and full 1-word/cycle throughput.
- Adds an occupancy count, almost-full/almost-empty flags and a synchronous flush.
- Used as the general buffering block between streaming pipeline stages.

Parameters:
- DEPTH_LG2, 4, log2 of SRAM entries; SRAM depth D = 2^DEPTH_LG2; total capacity CAP = D+2.
- DATA_WIDTH, 32, payload width in bits.
- AF_THRESH, 14, almost_full_o asserts when count >= AF_THRESH (legal range 1..CAP).
- AE_THRESH, 2, almost_empty_o asserts when count <= AE_THRESH (legal range 0..CAP-1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous clear of all contents.
- s_valid_i  in  1  write request.
- s_ready_o  out  1  FIFO can accept a word this cycle.
- s_data_i  in  DATA_WIDTH  write data.
- m_valid_o  out  1  head word valid on m_data_o.
- m_ready_i  in  1  consumer accepts head word.
- m_data_o  out  DATA_WIDTH  head word.
- count_o  out  DEPTH_LG2+2  words held: SRAM + in-flight read + output stage.
- almost_full_o  out  1  count_o >= AF_THRESH.
- almost_empty_o  out  1  count_o <= AE_THRESH.

Behaviour:
- Reset and interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: s_ready_o=1, m_valid_o=0, m_data_o=0, count_o=0, almost_empty_o=1, almost_full_o=0. SRAM contents are not reset.
- Priority: rst > flush_i > normal operation.
- Push: occurs when s_valid_i & s_ready_o. The word is written to SRAM[wrptr] and wrptr increments. Pointers are DEPTH_LG2+1 bits; the MSB is the wrap bit.
- Pop: occurs when m_valid_o & m_ready_i. The output stage shifts; the skid entry, if present, becomes the head in the next cycle.
- s_ready_o: registered; equals (SRAM occupancy < D) after the edge. There is no same-cycle pass-through from pop to ready.
- Prefetch: an SRAM read of SRAM[rdptr] is issued in a cycle when both hold:
  - SRAM occupancy > 0 at the start of the cycle;
  - (out_entries + inflight - pop) < 2.
  - rdptr increments on issue. Read data lands in the output stage one cycle later. Output order is preserved.
- Latency: a word pushed in cycle N into an empty FIFO is readable as SRAM data in N+1 (read issued), and appears with m_valid_o=1 in N+2.
- Throughput: once streaming, one pop per cycle with no bubbles while the SRAM is non-empty.
- Read-during-write: a read is only issued when occupancy > 0, so the same address is never read and written in one cycle. A push is never accepted when the SRAM is full.
- count_o: registered; next = count + push - pop. The prefetch move does not change it. Always 0 <= count_o <= CAP.
- Flags: almost_full_o and almost_empty_o are registered, derived from next count, and updated together with count_o.
- Flush:
  - Next cycle: pointers are equal, count_o=0, m_valid_o=0, s_ready_o=1.
  - A concurrent push is dropped and a concurrent pop is ignored.
  - An in-flight read is discarded and must not produce m_valid_o.
- m_data_o: holds its last value when m_valid_o=0.
- Protocol: s_data_i is only sampled on a push. m_data_o is stable while m_valid_o & !m_ready_i.
- Sim-only assertions: count_o never exceeds CAP; m_valid_o never drops without a pop or flush.

Test Plan:
- Reset: assert rst 3 cycles with s_valid_i=1 -> s_ready_o=1, m_valid_o=0, count_o=0, almost_empty_o=1 throughout, and no word accepted.
- Single word: push 0xA5 in cycle 0 with m_ready_i=1 -> m_valid_o=1 with m_data_o=0xA5 in cycle 2; count_o goes 1 then 0 after the pop; m_valid_o=0 in cycle 3.
- Fill (D=16, m_ready_i=0): push words 0..N continuously -> exactly 18 words accepted, then s_ready_o=0; count_o=18; almost_full_o rises when count_o reaches 14; m_data_o=0. Then drain -> values 0..17 in order, with count_o=0 and almost_empty_o=1 at the end.
- Streaming: s_valid_i=1 and m_ready_i=1 for 100 words -> first pop in cycle 2, then one pop per cycle with no gaps; all 100 words in order; count_o stays at 2 in steady state.
- Random backpressure: 500 words, s_valid_i and m_ready_i each random at 50% -> scoreboard shows in-order delivery with no loss or duplication; count_o always matches the model and never exceeds 18.
- Flush: with count_o=10 and an in-flight read, assert flush_i together with a push of 0x77 -> next cycle count_o=0, m_valid_o=0, and 0x77 never emerges. A following push of 0x33 appears 2 cycles later.
